if_stage: RTL
=============

Name: if_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage MIPS core.
- Sits directly downstream of the ID-stage branch comparator. It consumes the comparator's taken flag, together with the decoded jump/branch controls from ID, to select the next PC.
- Holds the PC register, drives the instruction-memory word address, and latches instruction/PC into the IF/ID register under hazard-unit stall control.
- Architectural branch delay slot: no flush logic.

Parameters:
- PC_RESET, 32'h0000_3000, PC value loaded on reset (text segment base).
- IMEM_AW, 10, instruction-memory word-address width (1024 words).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  from hazard unit; freezes PC and IF/ID register.
- judge  in  1  branch-taken flag from the ID comparator.
- br_op  in  1  ID instruction is beq/bne/bgez-class conditional branch.
- br_imm  in  16  ID instruction imm16.
- j_op  in  1  ID instruction is j/jal.
- j_index  in  26  ID instruction instr_index.
- jr_op  in  1  ID instruction is jr/jalr.
- jr_target  in  32  forwarded rs value from ID.
- imem_addr  out  IMEM_AW  word address to instruction ROM (combinational read).
- imem_instr  in  32  instruction word returned for imem_addr in the same cycle.
- IR_D  out  32  IF/ID instruction register.
- PC_D  out  32  IF/ID PC register.
- PC8_D  out  32  PC_D+8, link value for jal/jalr.
- valid_D  out  1  IF/ID register holds a fetched instruction (0 = reset bubble).
- PC_F  out  32  current fetch PC (debug/trace).

Behaviour:
- Reset values:
  - Reset is synchronous: it takes effect on the clk edge where reset=1.
  - After that edge: PC_F=PC_RESET, IR_D=32'h0 (nop), PC_D=32'h0, valid_D=0.
  - PC8_D is combinational, so it reads 32'h8 after reset.
  - Reset has priority over stall and over every redirect input.
- imem_addr = (PC_F - PC_RESET)[IMEM_AW+1:2]. This is combinational. Addresses beyond the ROM wrap modulo 2^IMEM_AW.
- Target computation (all combinational, 32-bit, carries discarded):
  - seq = PC_F + 4.
  - br_tgt = PC_D + 4 + (sign_extend(br_imm) << 2).
  - j_tgt = {PC_D[31:28], j_index, 2'b00}. Upper bits come from the delay-slot address region; PC_D[31:28] is used directly.
  - jr_tgt = jr_target.
- Next-PC priority, applied when stall=0:
  1. jr_op
  2. j_op
  3. br_op && judge
  4. seq
- Control-input rules when valid_D=0: br_op, j_op and jr_op are ignored, and next PC is seq.
- One-hot violation: if more than one of jr_op, j_op, br_op is asserted, the priority above still resolves it deterministically.
- Per-edge update, stall=0:
  - PC_F <= next PC.
  - IR_D <= imem_instr.
  - PC_D <= PC_F.
  - valid_D <= 1.
  - The instruction fetched in the cycle a branch/jump is in ID is the delay slot. It is always latched.
- Per-edge update, stall=1:
  - PC_F, IR_D, PC_D and valid_D hold.
  - Redirect inputs are ignored that cycle. ID re-presents the same controls on the next unstalled cycle, where they are applied (stall then release = redirect applied exactly once).
- Latency:
  - Redirect decided in cycle N (unstalled) → target PC visible on PC_F in cycle N+1.
  - Target instruction appears on IR_D in cycle N+2.
- Misaligned targets (low bits ≠ 00) are fetched as-is. imem_addr truncates the low bits; no exception is raised.
- Reset asserted mid-stall or mid-redirect: the reset state wins on that edge; nothing pending survives.

Decomposition:
- Shared head include holds:
  - PC_RESET default.
  - opcode constants used by the ID decode that produces br_op/j_op/jr_op.
  - NOP encoding 32'h0.
- Natural sub-module: npc (combinational next-PC mux and target adders).
- if_stage instantiates npc and owns the PC and IF/ID registers.

Test Plan:
- Reset then 3 free-running cycles, no controls → PC_F 3000,3004,3008,300C; IR_D follows ROM words 0..2; valid_D goes 1 on the first post-reset edge.
- beq at 0x3000 in ID, br_imm=16'h0003, judge=1 → delay slot 0x3004 latched into IR_D; PC_F next = 0x3010.
- Same beq with judge=0 → PC_F proceeds 0x3008 sequentially.
- bne at 0x3010, br_imm=16'hFFFC, judge=1 → target 0x3004 (backward, sign extension checked).
- jal at PC_D=0x3020, j_index=26'h0000C10 → PC_F next 0x3040; PC8_D=0x3028.
- jr with jr_target=0x3100, stall=1 for 2 cycles then 0 → PC_F, IR_D and PC_D constant during the stall; PC_F=0x3100 one cycle after release, applied once.
- reset=1 while stall=1 and j_op=1 → next edge PC_F=0x3000, IR_D=0, valid_D=0.

Source files
------------

// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared constants for the fetch stage and the ID decode feeding it.
//   PC_RESET_DEF / IMEM_AW_DEF : default reset PC and instruction ROM word-address width
//   NOP                        : encoding latched into IF/ID on reset (sll $0,$0,0)
//   OP_* / FUNCT_*             : opcodes the ID decode uses to raise br_op/j_op/jr_op
//   npc_sel_e                  : next-PC source select
//   br_offset                  : sign-extended, word-scaled branch displacement
package if_stage_pkg;

  localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;
  localparam int unsigned IMEM_AW_DEF  = 10;
  localparam logic [31:0] NOP          = 32'h0000_0000;

  localparam logic [5:0] OP_SPECIAL  = 6'b000000;
  localparam logic [5:0] OP_REGIMM   = 6'b000001;
  localparam logic [5:0] OP_J        = 6'b000010;
  localparam logic [5:0] OP_JAL      = 6'b000011;
  localparam logic [5:0] OP_BEQ      = 6'b000100;
  localparam logic [5:0] OP_BNE      = 6'b000101;
  localparam logic [5:0] FUNCT_JR    = 6'b001000;
  localparam logic [5:0] FUNCT_JALR  = 6'b001001;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'd0,
    NPC_BR  = 2'd1,
    NPC_J   = 2'd2,
    NPC_JR  = 2'd3
  } npc_sel_e;

  function automatic logic [31:0] br_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_npc.sv
// if_stage_npc: combinational next-PC mux and target adders.
//   pc_f_i      : current fetch PC           pc_d_i      : PC of instruction in ID
//   valid_d_i   : ID holds a real instruction (controls ignored otherwise)
//   br_op_i/judge_i/br_imm_i : conditional branch control, taken flag, imm16
//   j_op_i/j_index_i         : j/jal control and instr_index
//   jr_op_i/jr_target_i      : jr/jalr control and forwarded rs value
//   npc_o       : PC to load on the next unstalled edge
module if_stage_npc
  import if_stage_pkg::*;
(
  input  logic [31:0] pc_f_i,
  input  logic [31:0] pc_d_i,
  input  logic        valid_d_i,
  input  logic        br_op_i,
  input  logic        judge_i,
  input  logic [15:0] br_imm_i,
  input  logic        j_op_i,
  input  logic [25:0] j_index_i,
  input  logic        jr_op_i,
  input  logic [31:0] jr_target_i,
  output logic [31:0] npc_o
);

  logic [31:0] seq;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  npc_sel_e    sel;

  assign seq    = pc_f_i + 32'd4;
  // Branch and jump targets are relative to the delay-slot address region (PC_D).
  assign br_tgt = pc_d_i + 32'd4 + br_offset(br_imm_i);
  assign j_tgt  = {pc_d_i[31:28], j_index_i, 2'b00};

  // Fixed priority jr > j > taken branch > sequential; resolves multi-hot controls too.
  always_comb begin
    sel = NPC_SEQ;
    if (valid_d_i) begin
      if (jr_op_i)                 sel = NPC_JR;
      else if (j_op_i)             sel = NPC_J;
      else if (br_op_i && judge_i) sel = NPC_BR;
    end
  end

  always_comb begin
    npc_o = seq;
    case (sel)
      NPC_JR:  npc_o = jr_target_i;
      NPC_J:   npc_o = j_tgt;
      NPC_BR:  npc_o = br_tgt;
      default: npc_o = seq;
    endcase
  end

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch PC register plus IF/ID pipeline register.
//   clk, reset (sync, active-high), stall (freeze PC and IF/ID)
//   judge/br_op/br_imm, j_op/j_index, jr_op/jr_target : redirect controls from ID
//   imem_addr  : ROM word address (combinational)   imem_instr : ROM data, same cycle
//   IR_D, PC_D, valid_D : IF/ID register            PC8_D : PC_D + 8 link value
//   PC_F       : current fetch PC
// Branch delay slot is architectural: the instruction fetched alongside a
// redirect is always latched, so there is no flush path.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEF,
  parameter int unsigned IMEM_AW  = IMEM_AW_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               judge,
  input  logic               br_op,
  input  logic [15:0]        br_imm,
  input  logic               j_op,
  input  logic [25:0]        j_index,
  input  logic               jr_op,
  input  logic [31:0]        jr_target,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_instr,
  output logic [31:0]        IR_D,
  output logic [31:0]        PC_D,
  output logic [31:0]        PC8_D,
  output logic               valid_D,
  output logic [31:0]        PC_F
);

  logic [31:0] pc_f_q, pc_f_d;
  logic [31:0] ir_d_q;
  logic [31:0] pc_d_q;
  logic        valid_d_q;
  logic [31:0] pc_ofs;

  if_stage_npc u_npc (
    .pc_f_i      (pc_f_q),
    .pc_d_i      (pc_d_q),
    .valid_d_i   (valid_d_q),
    .br_op_i     (br_op),
    .judge_i     (judge),
    .br_imm_i    (br_imm),
    .j_op_i      (j_op),
    .j_index_i   (j_index),
    .jr_op_i     (jr_op),
    .jr_target_i (jr_target),
    .npc_o       (pc_f_d)
  );

  // Reset beats stall and redirects; stall holds all fetch state.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_f_q    <= PC_RESET;
      ir_d_q    <= NOP;
      pc_d_q    <= 32'h0;
      valid_d_q <= 1'b0;
    end else if (!stall) begin
      pc_f_q    <= pc_f_d;
      ir_d_q    <= imem_instr;
      pc_d_q    <= pc_f_q;
      valid_d_q <= 1'b1;
    end
  end

  // Byte offset into the text segment; low bits dropped, high bits wrap the ROM.
  assign pc_ofs    = pc_f_q - PC_RESET;
  assign imem_addr = IMEM_AW'(pc_ofs >> 2);

  assign PC_F    = pc_f_q;
  assign IR_D    = ir_d_q;
  assign PC_D    = pc_d_q;
  assign PC8_D   = pc_d_q + 32'd8;
  assign valid_D = valid_d_q;

endmodule
